// File: rtl/fp_result_uart_tx.sv
// UART transmitter for FP calculator results: latches {op, result} on start and
// sends a 5-byte 8N1 packet (header with opcode, then result bytes LSB first).
module fp_result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [3:0]  HDR_NIBBLE   = 4'hA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] result,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   res_q, res_d;
    logic          tx_q, tx_d;

    logic          accept;
    logic          baud_last;
    logic [7:0]    cur_byte;

    function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                            input logic [1:0]  o,
                                            input logic [31:0] r);
        case (idx)
            3'd0:    pkt_byte = {HDR_NIBBLE, 2'b00, o};
            3'd1:    pkt_byte = r[7:0];
            3'd2:    pkt_byte = r[15:8];
            3'd3:    pkt_byte = r[23:16];
            default: pkt_byte = r[31:24];
        endcase
    endfunction

    assign busy      = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign done      = (state_q == S_DONE);
    assign tx        = tx_q;
    assign accept    = start && !busy;
    assign baud_last = (baud_q == BAUD_MAX);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        op_d     = op_q;
        res_d    = res_q;
        cur_byte = 8'h00;
        tx_d     = 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                byte_d  = '0;
                if (accept) begin
                    state_d = S_START;
                    op_d    = op;
                    res_d   = result;
                end
            end
            S_START: begin
                baud_d = baud_last ? '0 : baud_q + 1'b1;
                if (baud_last) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                baud_d = baud_last ? '0 : baud_q + 1'b1;
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                baud_d = baud_last ? '0 : baud_q + 1'b1;
                if (baud_last) begin
                    if (byte_q < 3'd4) begin
                        state_d = S_START;
                        byte_d  = byte_q + 3'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx is registered from the next-state values so the pin changes cleanly with state_q
        cur_byte = pkt_byte(byte_d, op_d, res_d);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            op_q    <= '0;
            res_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            op_q    <= op_d;
            res_q   <= res_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_fp_result_uart_tx.sv
// Directed bench for fp_result_uart_tx with CLKS_PER_BIT=4 (200-cycle packets).
module tb_fp_result_uart_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] result;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    fp_result_uart_tx #(
        .CLKS_PER_BIT(C),
        .HDR_NIBBLE  (4'hA)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .result(result),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [1:0] o, input logic [31:0] r);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        result = r;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 'x;
        result = 'x;
    endtask

    // Called just after the accepting edge; checks every cycle of the packet against
    // exp = {B4,B3,B2,B1,B0}, optionally pulses a stray start at cycle ghost_k, and
    // optionally accepts a follow-on packet in the done cycle.
    task automatic check_packet(input string name, input logic [39:0] exp, input int ghost_k,
                                input logic chain, input logic [1:0] nop, input logic [31:0] nres);
        logic [7:0] rx;
        int b, p, j, pos;
        logic e;
        rx = 8'h00;
        for (int k = 1; k <= 50 * C; k++) begin
            @(negedge clk);
            b   = (k - 1) / C;
            p   = (k - 1) % C;
            j   = b / 10;
            pos = b % 10;
            if (pos == 0)      e = 1'b0;
            else if (pos == 9) e = 1'b1;
            else               e = exp[j*8 + pos - 1];
            chk($sformatf("%s tx k=%0d", name, k), {7'b0, tx}, {7'b0, e});
            chk($sformatf("%s busy k=%0d", name, k), {7'b0, busy}, 8'h01);
            chk($sformatf("%s done k=%0d", name, k), {7'b0, done}, 8'h00);
            if (p == C / 2) begin
                if (pos >= 1 && pos <= 8) rx = {tx, rx[7:1]};
                if (pos == 9) chk($sformatf("%s byte%0d", name, j), rx, exp[j*8 +: 8]);
            end
            if (k == ghost_k) begin
                start  = 1'b1;
                op     = 2'b00;
                result = 32'h0;
            end
            if (k == ghost_k + 1) begin
                start  = 1'b0;
                op     = 'x;
                result = 'x;
            end
        end
        @(negedge clk);
        chk({name, " done pulse"}, {5'b0, tx, busy, done}, 8'b101);
        if (chain) begin
            start  = 1'b1;
            op     = nop;
            result = nres;
            @(posedge clk);
            #1;
            start  = 1'b0;
            op     = 'x;
            result = 'x;
        end else begin
            @(negedge clk);
            chk({name, " after done"}, {5'b0, tx, busy, done}, 8'b100);
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        result = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset state", {5'b0, tx, busy, done}, 8'b100);
        reset = 1'b1;
        @(negedge clk);
        chk("idle after release", {5'b0, tx, busy, done}, 8'b100);

        // Test 1 chained into test 4 during the done cycle
        accept(2'b00, 32'h41000000);
        check_packet("t1", 40'h41_00_00_00_A0, -1, 1'b1, 2'b11, 32'hDEADBEEF);
        check_packet("t4", 40'hDE_AD_BE_EF_A3, -1, 1'b0, 2'b00, 32'h0);

        accept(2'b01, 32'h40A00000);
        check_packet("t2", 40'h40_A0_00_00_A1, -1, 1'b0, 2'b00, 32'h0);

        accept(2'b10, 32'h41000000);
        check_packet("t3", 40'h41_00_00_00_A2, 50, 1'b0, 2'b00, 32'h0);

        // Test 5: reset at cycle 70 (byte 1, data bit 6 of 0x00 -> tx low)
        accept(2'b00, 32'h41000000);
        repeat (70) @(negedge clk);
        chk("t5 tx before reset", {5'b0, tx, busy, done}, 8'b010);
        reset = 1'b0;
        #1;
        chk("t5 async reset", {5'b0, tx, busy, done}, 8'b100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5 in reset %0d", i), {5'b0, tx, busy, done}, 8'b100);
        end
        reset = 1'b1;
        for (int i = 0; i < 8 * C; i++) begin
            @(negedge clk);
            chk($sformatf("t5 no done %0d", i), {5'b0, tx, busy, done}, 8'b100);
        end
        accept(2'b00, 32'h3F800000);
        check_packet("t5", 40'h3F_80_00_00_A0, -1, 1'b0, 2'b00, 32'h0);

        // Test 6: long idle with junk on op/result
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            op     = (i % 2 == 0) ? 2'bxx : 2'($urandom);
            result = (i % 2 == 0) ? 'x : $urandom;
            chk($sformatf("t6 idle %0d", i), {5'b0, tx, busy, done}, 8'b100);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
